fwd_stall_unit: RTL and testbench

Parametrised forwarding and interlock controller for the 5-stage RISC-V pipeline (F, D, X, M, W).
- Compares the source registers of the instruction in D against the destinations in X and M.
- Drives the X-stage operand-forwarding selects one cycle later, when that instruction reaches X.
- Generates load-use / interlock stalls, bubbles and branch-redirect flushes.
- Keeps saturating performance counters for stall cycles and flush events.

---
 rtl/rv_pipe_pkg.sv | 21 ++
 rtl/fwd_src_cmp.sv | 39 +++
 rtl/fwd_stall_unit.sv | 136 +++++++++++++
 tb/tb_fwd_stall_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and the register-index width default.
package rv_pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // The X-stage producer is newer than the M-stage one, so it wins.
    function automatic logic [1:0] pick_fwd(input logic match_x, input logic match_m);
        if (match_x) begin
            return FWD_MEM;
        end
        if (match_m) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// Compares one D-stage source register against the X and M destinations.
module fwd_src_cmp
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int LOAD_STALL = 1
) (
    input  logic              d_valid,
    input  logic              use_src,
    input  logic [REG_AW-1:0] src,
    input  logic              x_valid,
    input  logic              x_wen,
    input  logic              x_load,
    input  logic [REG_AW-1:0] x_rd,
    input  logic              m_valid,
    input  logic              m_wen,
    input  logic              m_load,
    input  logic [REG_AW-1:0] m_rd,
    output logic              match_x,
    output logic              match_m,
    output logic              load_hit
);

    logic src_live;

    // x0 is hard-wired zero, so it never creates a dependency.
    assign src_live = d_valid & use_src & (src != '0);
    assign match_x  = src_live & x_valid & x_wen & (x_rd == src);
    assign match_m  = src_live & m_valid & m_wen & (m_rd == src);

    generate
        if (LOAD_STALL == 2) begin : g_two_cycle
            assign load_hit = (match_x & x_load) | (match_m & m_load);
        end else begin : g_one_cycle
            assign load_hit = match_x & x_load;
        end
    endgenerate

endmodule

// File: rtl/fwd_stall_unit.sv
// Forwarding / interlock controller for the 5-stage pipeline: operand selects, stalls,
// bubbles, redirect flushes and saturating stall/flush performance counters.
module fwd_stall_unit
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic              x_valid,
    input  logic              x_wen,
    input  logic              x_load,
    input  logic [REG_AW-1:0] x_rd,
    input  logic              m_valid,
    input  logic              m_wen,
    input  logic              m_load,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              x_redirect,
    input  logic              perf_clr,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_x,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    logic       mx_a, mm_a, lh_a;
    logic       mx_b, mm_b, lh_b;
    logic       hazard;
    logic [1:0] sel_a_next, sel_b_next;

    fwd_src_cmp #(.REG_AW(REG_AW), .LOAD_STALL(LOAD_STALL)) u_cmp_rs1 (
        .d_valid (d_valid),
        .use_src (d_use_rs1),
        .src     (d_rs1),
        .x_valid (x_valid),
        .x_wen   (x_wen),
        .x_load  (x_load),
        .x_rd    (x_rd),
        .m_valid (m_valid),
        .m_wen   (m_wen),
        .m_load  (m_load),
        .m_rd    (m_rd),
        .match_x (mx_a),
        .match_m (mm_a),
        .load_hit(lh_a)
    );

    fwd_src_cmp #(.REG_AW(REG_AW), .LOAD_STALL(LOAD_STALL)) u_cmp_rs2 (
        .d_valid (d_valid),
        .use_src (d_use_rs2),
        .src     (d_rs2),
        .x_valid (x_valid),
        .x_wen   (x_wen),
        .x_load  (x_load),
        .x_rd    (x_rd),
        .m_valid (m_valid),
        .m_wen   (m_wen),
        .m_load  (m_load),
        .m_rd    (m_rd),
        .match_x (mx_b),
        .match_m (mm_b),
        .load_hit(lh_b)
    );

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign hazard = lh_a | lh_b;
        end else begin : g_interlock
            assign hazard = mx_a | mm_a | mx_b | mm_b;
        end
    endgenerate

    // Redirect squashes the D instruction, so it overrides any hazard; reset gates everything.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_x    = 1'b0;
        sel_a_next = FWD_RF;
        sel_b_next = FWD_RF;
        if (!rst) begin
            if (x_redirect) begin
                flush_d = 1'b1;
                flush_x = 1'b1;
            end else if (hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_x = 1'b1;
            end
        end
        if ((FWD_EN != 0) && !hazard && !x_redirect) begin
            sel_a_next = pick_fwd(mx_a, mm_a);
            sel_b_next = pick_fwd(mx_b, mm_b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            fwd_a_sel <= sel_a_next;
            fwd_b_sel <= sel_b_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_d && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (x_redirect && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Bench for fwd_stall_unit: three configurations share one stimulus stream and are
// compared against a rule-level model of hazards, selects and counters.
module tb_fwd_stall_unit;

    localparam int NC  = 3;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst;
    logic d_valid, d_use_rs1, d_use_rs2;
    logic x_valid, x_wen, x_load, m_valid, m_wen, m_load;
    logic x_redirect, perf_clr;
    logic [4:0] d_rs1, d_rs2, x_rd, m_rd;

    logic [1:0]    fa [NC];
    logic [1:0]    fb [NC];
    logic          sf [NC];
    logic          sd [NC];
    logic          fd [NC];
    logic          fx [NC];
    logic [CW-1:0] sc [NC];
    logic [CW-1:0] fe [NC];

    int cfg_fwd [NC] = '{1, 1, 0};
    int cfg_ls  [NC] = '{1, 2, 1};

    logic [1:0] m_sa [NC];
    logic [1:0] m_sb [NC];
    int         m_sc [NC];
    int         m_fe [NC];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_stall_unit #(.REG_AW(5), .FWD_EN(1), .LOAD_STALL(1), .CNT_W(CW)) u_fwd1 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .x_valid(x_valid), .x_wen(x_wen),
        .x_load(x_load), .x_rd(x_rd), .m_valid(m_valid), .m_wen(m_wen), .m_load(m_load),
        .m_rd(m_rd), .x_redirect(x_redirect), .perf_clr(perf_clr),
        .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]), .stall_f(sf[0]), .stall_d(sd[0]),
        .flush_d(fd[0]), .flush_x(fx[0]), .stall_cycles(sc[0]), .flush_events(fe[0])
    );

    fwd_stall_unit #(.REG_AW(5), .FWD_EN(1), .LOAD_STALL(2), .CNT_W(CW)) u_fwd2 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .x_valid(x_valid), .x_wen(x_wen),
        .x_load(x_load), .x_rd(x_rd), .m_valid(m_valid), .m_wen(m_wen), .m_load(m_load),
        .m_rd(m_rd), .x_redirect(x_redirect), .perf_clr(perf_clr),
        .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]), .stall_f(sf[1]), .stall_d(sd[1]),
        .flush_d(fd[1]), .flush_x(fx[1]), .stall_cycles(sc[1]), .flush_events(fe[1])
    );

    fwd_stall_unit #(.REG_AW(5), .FWD_EN(0), .LOAD_STALL(1), .CNT_W(CW)) u_ilk (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .x_valid(x_valid), .x_wen(x_wen),
        .x_load(x_load), .x_rd(x_rd), .m_valid(m_valid), .m_wen(m_wen), .m_load(m_load),
        .m_rd(m_rd), .x_redirect(x_redirect), .perf_clr(perf_clr),
        .fwd_a_sel(fa[2]), .fwd_b_sel(fb[2]), .stall_f(sf[2]), .stall_d(sd[2]),
        .flush_d(fd[2]), .flush_x(fx[2]), .stall_cycles(sc[2]), .flush_events(fe[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Hazard and next selects straight from the pipeline rules for configuration c.
    task automatic model_eval(input int c, output logic hz, output logic [1:0] na, output logic [1:0] nb);
        int   src  [2];
        logic used [2];
        logic mx   [2];
        logic mm   [2];
        logic [1:0] sel [2];
        src[0] = int'(d_rs1);
        src[1] = int'(d_rs2);
        used[0] = d_use_rs1;
        used[1] = d_use_rs2;
        hz = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mx[s] = d_valid && used[s] && src[s] != 0 && x_valid && x_wen && int'(x_rd) == src[s];
            mm[s] = d_valid && used[s] && src[s] != 0 && m_valid && m_wen && int'(m_rd) == src[s];
            if (cfg_fwd[c] == 1) begin
                if (mx[s] && x_load) hz = 1'b1;
                if (cfg_ls[c] == 2 && mm[s] && m_load) hz = 1'b1;
            end else if (mx[s] || mm[s]) begin
                hz = 1'b1;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (hz || x_redirect || cfg_fwd[c] == 0) sel[s] = 2'b00;
            else if (mx[s]) sel[s] = 2'b01;
            else if (mm[s]) sel[s] = 2'b10;
            else sel[s] = 2'b00;
        end
        na = sel[0];
        nb = sel[1];
    endtask

    task automatic check_comb(input int c);
        logic hz;
        logic [1:0] na, nb;
        model_eval(c, hz, na, nb);
        check_eq($sformatf("stall_f[%0d]", c), 32'(sf[c]), 32'(!rst && hz && !x_redirect));
        check_eq($sformatf("stall_d[%0d]", c), 32'(sd[c]), 32'(!rst && hz && !x_redirect));
        check_eq($sformatf("flush_d[%0d]", c), 32'(fd[c]), 32'(!rst && x_redirect));
        check_eq($sformatf("flush_x[%0d]", c), 32'(fx[c]), 32'(!rst && (hz || x_redirect)));
    endtask

    task automatic check_reg(input int c);
        check_eq($sformatf("fwd_a_sel[%0d]", c), 32'(fa[c]), 32'(m_sa[c]));
        check_eq($sformatf("fwd_b_sel[%0d]", c), 32'(fb[c]), 32'(m_sb[c]));
        check_eq($sformatf("stall_cycles[%0d]", c), 32'(sc[c]), 32'(m_sc[c]));
        check_eq($sformatf("flush_events[%0d]", c), 32'(fe[c]), 32'(m_fe[c]));
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_sa[c] = 2'b00;
            m_sb[c] = 2'b00;
            m_sc[c] = 0;
            m_fe[c] = 0;
        end
    endtask

    task automatic clear_in();
        d_valid = 0; d_use_rs1 = 0; d_use_rs2 = 0; d_rs1 = 0; d_rs2 = 0;
        x_valid = 0; x_wen = 0; x_load = 0; x_rd = 0;
        m_valid = 0; m_wen = 0; m_load = 0; m_rd = 0;
        x_redirect = 0; perf_clr = 0;
    endtask

    // Inputs are already driven; check combinational outputs, clock once, check state.
    task automatic step();
        logic hz;
        logic [1:0] na, nb;
        #1;
        for (int c = 0; c < NC; c++) check_comb(c);
        @(posedge clk);
        for (int c = 0; c < NC; c++) begin
            model_eval(c, hz, na, nb);
            m_sa[c] = na;
            m_sb[c] = nb;
            if (perf_clr) begin
                m_sc[c] = 0;
                m_fe[c] = 0;
            end else begin
                if (hz && !x_redirect) m_sc[c] = (m_sc[c] + 1 > SAT) ? SAT : m_sc[c] + 1;
                if (x_redirect) m_fe[c] = (m_fe[c] + 1 > SAT) ? SAT : m_fe[c] + 1;
            end
        end
        #1;
        for (int c = 0; c < NC; c++) check_reg(c);
    endtask

    task automatic load_use_x7();
        clear_in();
        x_valid = 1; x_wen = 1; x_load = 1; x_rd = 7;
        d_valid = 1; d_use_rs2 = 1; d_rs2 = 7;
    endtask

    initial begin
        clear_in();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            check_comb(c);
            check_reg(c);
        end
        rst = 0;

        // Load-use: X holds lw x7, D reads x7 through rs2.
        load_use_x7();
        step();
        check_eq("lu_bubble_sel_b", 32'(fb[0]), 32'h0);
        clear_in();
        m_valid = 1; m_wen = 1; m_load = 1; m_rd = 7;
        d_valid = 1; d_use_rs2 = 1; d_rs2 = 7;
        step();
        check_eq("lu_wb_sel_b", 32'(fb[0]), 32'h2);
        check_eq("lu_ls1_stalls", 32'(sc[0]), 32'd1);
        check_eq("lu_ls2_stalls", 32'(sc[1]), 32'd2);
        clear_in();
        d_valid = 1; d_use_rs2 = 1; d_rs2 = 7;
        step();

        // ALU producer in X forwards from M next cycle.
        clear_in();
        x_valid = 1; x_wen = 1; x_rd = 5;
        d_valid = 1; d_use_rs1 = 1; d_rs1 = 5;
        step();
        check_eq("alu_fwd_a", 32'(fa[0]), 32'h1);

        // Redirect together with a load-use hazard: only the flush happens.
        load_use_x7();
        x_redirect = 1;
        #1;
        check_eq("redir_no_stall", 32'(sd[0]), 32'h0);
        step();
        check_eq("redir_sel_b", 32'(fb[0]), 32'h0);
        check_eq("redir_flush_cnt", 32'(fe[0]), 32'h1);

        // x0 never matches, even for a load writing x0.
        clear_in();
        x_valid = 1; x_wen = 1; x_load = 1; x_rd = 0;
        d_valid = 1; d_use_rs1 = 1; d_rs1 = 0;
        step();
        check_eq("x0_sel_a", 32'(fa[0]), 32'h0);

        // Interlock mode stalls on an M-stage ALU producer.
        clear_in();
        m_valid = 1; m_wen = 1; m_rd = 3;
        d_valid = 1; d_use_rs1 = 1; d_rs1 = 3;
        #1;
        check_eq("ilk_stall", 32'(sd[2]), 32'h1);
        step();
        check_eq("ilk_sel_a", 32'(fa[2]), 32'h0);

        // Random traffic over a small register range to provoke overlaps.
        for (int i = 0; i < 400; i++) begin
            d_valid    = ($urandom_range(0, 7) != 0);
            d_use_rs1  = $urandom_range(0, 1);
            d_use_rs2  = $urandom_range(0, 1);
            d_rs1      = 5'($urandom_range(0, 3));
            d_rs2      = 5'($urandom_range(0, 3));
            x_valid    = $urandom_range(0, 1);
            x_wen      = ($urandom_range(0, 3) != 0);
            x_load     = $urandom_range(0, 1);
            x_rd       = 5'($urandom_range(0, 3));
            m_valid    = $urandom_range(0, 1);
            m_wen      = ($urandom_range(0, 3) != 0);
            m_load     = $urandom_range(0, 1);
            m_rd       = 5'($urandom_range(0, 3));
            x_redirect = ($urandom_range(0, 7) == 0);
            perf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end

        // Saturation, clear-over-increment, then reset while stalled.
        load_use_x7();
        repeat (20) step();
        check_eq("sat_stall_cnt", 32'(sc[0]), 32'(SAT));
        perf_clr = 1;
        step();
        check_eq("clr_over_inc", 32'(sc[0]), 32'h0);
        perf_clr = 0;
        step();
        rst = 1;
        #1;
        for (int c = 0; c < NC; c++) begin
            check_eq($sformatf("rst_stall_d[%0d]", c), 32'(sd[c]), 32'h0);
            check_eq($sformatf("rst_flush_x[%0d]", c), 32'(fx[c]), 32'h0);
            check_eq($sformatf("rst_stall_cnt[%0d]", c), 32'(sc[c]), 32'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        clear_in();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
